// File: rtl/lut_chain_loader.sv
`default_nettype none
// ============================================================================
// Module   : lut_chain_loader
// Brief    : Assembles streamed words into LUT tables and shifts them down
//            the cell_logic chain with one init pulse per table.
// Revision : 1.0 - initial release
// ============================================================================
module lut_chain_loader #(
    parameter int NUM_INPUTS = 9,
    parameter int NUM_CELLS  = 16,
    parameter int WORD_W     = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [WORD_W-1:0]          word_in,
    input  logic                       word_valid,
    output logic                       word_ready,
    output logic [(2**NUM_INPUTS)-1:0] logic_inputs,
    output logic                       init,
    output logic                       busy,
    output logic                       done
);

    localparam int c_table_w = 2 ** NUM_INPUTS;
    localparam int c_words   = c_table_w / WORD_W;
    localparam int c_wcw     = (c_words > 1)   ? $clog2(c_words)   : 1;
    localparam int c_ccw     = (NUM_CELLS > 1) ? $clog2(NUM_CELLS) : 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_SHIFT   = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_next;
    logic [c_wcw-1:0]       r_word_cnt;
    logic [c_ccw-1:0]       r_cell_cnt;
    logic [c_table_w-1:0]   r_asm;
    logic                   w_accept;
    logic                   w_last_word;
    logic                   w_last_cell;

    assign w_accept    = (r_state == S_COLLECT) && word_valid;
    assign w_last_word = (r_word_cnt == c_wcw'(c_words - 1));
    assign w_last_cell = (r_cell_cnt == c_ccw'(NUM_CELLS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (start) w_next = S_COLLECT;
            S_COLLECT: if (w_accept && w_last_word) w_next = S_SHIFT;
            S_SHIFT:   w_next = w_last_cell ? S_DONE : S_COLLECT;
            S_DONE:    w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_word_cnt <= '0;
            r_cell_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_word_cnt <= '0;
                        r_cell_cnt <= '0;
                    end
                end
                S_COLLECT: begin
                    if (w_accept) begin
                        r_word_cnt <= w_last_word ? '0 : r_word_cnt + 1'b1;
                    end
                end
                S_SHIFT: begin
                    if (!w_last_cell) begin
                        r_cell_cnt <= r_cell_cnt + 1'b1;
                        r_word_cnt <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Word 0 lands in the least-significant slice; the table is never cleared
    // because every slice is rewritten before the next init pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_asm <= '0;
        end else if (w_accept) begin
            r_asm[int'(r_word_cnt)*WORD_W +: WORD_W] <= word_in;
        end
    end

    assign logic_inputs = r_asm;
    assign word_ready   = (r_state == S_COLLECT);
    assign init         = (r_state == S_SHIFT);
    assign busy         = (r_state != S_IDLE);
    assign done         = (r_state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_lut_chain_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_lut_chain_loader
// Brief    : Directed self-checking bench for lut_chain_loader with a two-cell
//            chain model fed from logic_inputs/init.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lut_chain_loader;

    localparam int NI = 9;
    localparam int NC = 2;
    localparam int WW = 32;
    localparam int TW = 512;
    localparam int NW = 16;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [WW-1:0] word_in;
    logic          word_valid;
    logic          word_ready;
    logic [TW-1:0] logic_inputs;
    logic          init;
    logic          busy;
    logic          done;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int init_cnt = 0;
    int done_cnt = 0;
    logic [TW-1:0] cell0;
    logic [TW-1:0] cell1;

    lut_chain_loader #(
        .NUM_INPUTS(NI),
        .NUM_CELLS (NC),
        .WORD_W    (WW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .word_in     (word_in),
        .word_valid  (word_valid),
        .word_ready  (word_ready),
        .logic_inputs(logic_inputs),
        .init        (init),
        .busy        (busy),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Two-cell chain model: each init shifts cell0 into cell1.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (init) begin
            init_cnt <= init_cnt + 1;
            cell1    <= cell0;
            cell0    <= logic_inputs;
        end
        if (done) done_cnt <= done_cnt + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    function automatic logic [TW-1:0] ramp(input logic [WW-1:0] base);
        logic [TW-1:0] t;
        for (int i = 0; i < NW; i++) t[i*WW +: WW] = base + WW'(i);
        return t;
    endfunction

    function automatic logic [TW-1:0] fill(input logic [WW-1:0] w);
        logic [TW-1:0] t;
        for (int i = 0; i < NW; i++) t[i*WW +: WW] = w;
        return t;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic stream(input logic [TW-1:0] tbl, input int n, input bit stall,
                          output bit tmo, output int stall_inits);
        int idx;
        int guard;
        bit acc;
        idx = 0;
        guard = 0;
        stall_inits = 0;
        while (idx < n && guard < 400) begin
            word_valid = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            word_in    = tbl[idx*WW +: WW];
            acc        = word_valid && word_ready;
            tick();
            if (acc) idx++;
            if (init && idx < NW) stall_inits++;
            guard++;
        end
        word_valid = 1'b0;
        tmo = (idx < n);
    endtask

    task automatic wait_done(output int at, output bit tmo);
        int g;
        g = 0;
        while (!done && g < 200) begin
            tick();
            g++;
        end
        at  = cyc;
        tmo = !done;
    endtask

    task automatic run_load(input logic [TW-1:0] a, input logic [TW-1:0] b,
                            input bit with_start, output int cycles, output bit tmo);
        int t0;
        int at;
        int si;
        bit t1;
        bit t2;
        bit t3;
        if (with_start) do_start();
        t0 = cyc;
        stream(a, NW, 1'b0, t1, si);
        tick();
        stream(b, NW, 1'b0, t2, si);
        wait_done(at, t3);
        cycles = at - t0;
        tmo = t1 | t2 | t3;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({word_ready, init, busy, done} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_outputs got %b exp 0000", {word_ready, init, busy, done});
        end
        checks++;
        if (logic_inputs !== '0) begin
            errors++;
            $display("FAIL reset_logic_inputs got %h exp 0", logic_inputs);
        end
        tick();
        tick();
        rst_n = 1'b1;
        repeat (5) tick();
        checks++;
        if (busy !== 1'b0 || init_cnt !== 0) begin
            errors++;
            $display("FAIL reset_idle busy %b inits %0d exp 0 0", busy, init_cnt);
        end
    endtask

    task automatic test_slicing();
        logic [TW-1:0] ta;
        logic [TW-1:0] tb;
        bit tmo;
        int si;
        int t0;
        int at;
        ta = ramp(32'h0);
        tb = ramp(32'h100);
        do_start();
        t0 = cyc;
        checks++;
        if (busy !== 1'b1 || word_ready !== 1'b1) begin
            errors++;
            $display("FAIL start_latency busy %b ready %b exp 1 1", busy, word_ready);
        end
        stream(ta, NW, 1'b0, tmo, si);
        checks++;
        if (tmo || init !== 1'b1 || word_ready !== 1'b0) begin
            errors++;
            $display("FAIL slice_shift tmo %b init %b ready %b exp 0 1 0", tmo, init, word_ready);
        end
        checks++;
        if (logic_inputs[31:0] !== 32'h0 || logic_inputs[511:480] !== 32'hF) begin
            errors++;
            $display("FAIL slice_ends got %h/%h exp 0/f", logic_inputs[31:0], logic_inputs[511:480]);
        end
        checks++;
        if (logic_inputs !== ta) begin
            errors++;
            $display("FAIL slice_table got %h exp %h", logic_inputs, ta);
        end
        tick();
        checks++;
        if (init !== 1'b0 || word_ready !== 1'b1) begin
            errors++;
            $display("FAIL shift_one_cycle init %b ready %b exp 0 1", init, word_ready);
        end
        stream(tb, NW, 1'b0, tmo, si);
        wait_done(at, tmo);
        checks++;
        if (tmo || at - t0 !== NC * (NW + 1)) begin
            errors++;
            $display("FAIL load_cycles tmo %b got %0d exp %0d", tmo, at - t0, NC * (NW + 1));
        end
        tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL done_pulse done %b busy %b exp 0 0", done, busy);
        end
        checks++;
        if (cell1 !== ta || cell0 !== tb) begin
            errors++;
            $display("FAIL slice_chain cell1 %h cell0 %h exp %h %h", cell1[63:0], cell0[63:0], ta[63:0], tb[63:0]);
        end
    endtask

    task automatic test_ordering();
        logic [TW-1:0] a;
        logic [TW-1:0] b;
        int i0;
        int cycles;
        bit tmo;
        a = fill(32'hAAAAAAAA);
        b = fill(32'h55555555);
        i0 = init_cnt;
        run_load(a, b, 1'b1, cycles, tmo);
        tick();
        checks++;
        if (tmo || cell0[0] !== 1'b1 || cell1[0] !== 1'b0) begin
            errors++;
            $display("FAIL order_addr0 tmo %b cell0 %b cell1 %b exp 0 1 0", tmo, cell0[0], cell1[0]);
        end
        checks++;
        if (cell1 !== a || cell0 !== b) begin
            errors++;
            $display("FAIL order_tables cell1 %h cell0 %h", cell1[31:0], cell0[31:0]);
        end
        checks++;
        if (init_cnt - i0 !== 2) begin
            errors++;
            $display("FAIL order_init_count got %0d exp 2", init_cnt - i0);
        end
    endtask

    task automatic test_backpressure();
        logic [TW-1:0] tc;
        logic [TW-1:0] td;
        bit tmo;
        int si;
        int at;
        for (int i = 0; i < NW; i++) tc[i*WW +: WW] = $urandom;
        td = ramp(32'hC000_0000);
        do_start();
        stream(tc, NW, 1'b1, tmo, si);
        checks++;
        if (tmo || si !== 0 || init !== 1'b1) begin
            errors++;
            $display("FAIL bp_shift tmo %b stall_inits %0d init %b exp 0 0 1", tmo, si, init);
        end
        checks++;
        if (logic_inputs !== tc) begin
            errors++;
            $display("FAIL bp_table got %h exp %h", logic_inputs, tc);
        end
        tick();
        stream(td, NW, 1'b1, tmo, si);
        wait_done(at, tmo);
        tick();
        checks++;
        if (tmo || cell1 !== tc || cell0 !== td) begin
            errors++;
            $display("FAIL bp_chain tmo %b cell1 %h cell0 %h", tmo, cell1[31:0], cell0[31:0]);
        end
    endtask

    task automatic test_protocol_misuse();
        logic [TW-1:0] prev;
        logic [TW-1:0] a;
        logic [TW-1:0] b;
        int d0;
        int cycles;
        bit tmo;
        bit rdy_seen;
        prev = logic_inputs;
        a = ramp(32'h7000);
        b = ramp(32'h8000);
        rdy_seen = 1'b0;
        word_valid = 1'b1;
        word_in = 32'hDEADBEEF;
        repeat (4) begin
            tick();
            rdy_seen |= word_ready;
        end
        word_valid = 1'b0;
        checks++;
        if (rdy_seen || busy !== 1'b0 || logic_inputs !== prev) begin
            errors++;
            $display("FAIL idle_capture ready %b busy %b lsw %h exp 0 0 %h", rdy_seen, busy, logic_inputs[31:0], prev[31:0]);
        end
        d0 = done_cnt;
        do_start();
        start = 1'b1;
        tick();
        tick();
        start = 1'b0;
        run_load(a, b, 1'b0, cycles, tmo);
        repeat (3) tick();
        checks++;
        if (tmo || done_cnt - d0 !== 1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL misuse_done tmo %b count %0d busy %b exp 0 1 0", tmo, done_cnt - d0, busy);
        end
        checks++;
        if (cell1 !== a || cell0 !== b) begin
            errors++;
            $display("FAIL misuse_chain cell1 %h cell0 %h", cell1[31:0], cell0[31:0]);
        end
    endtask

    task automatic test_back_to_back();
        logic [TW-1:0] e;
        logic [TW-1:0] f;
        int cycles;
        bit tmo;
        e = ramp(32'h1111_0000);
        f = ramp(32'h2222_0000);
        run_load(fill(32'h0F0F0F0F), fill(32'hF0F0F0F0), 1'b1, cycles, tmo);
        tick();
        checks++;
        if (tmo || busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle tmo %b busy %b exp 0 0", tmo, busy);
        end
        run_load(e, f, 1'b1, cycles, tmo);
        checks++;
        if (tmo || cycles !== NC * (NW + 1)) begin
            errors++;
            $display("FAIL b2b_cycles tmo %b got %0d exp %0d", tmo, cycles, NC * (NW + 1));
        end
        tick();
        checks++;
        if (cell1 !== e || cell0 !== f) begin
            errors++;
            $display("FAIL b2b_chain cell1 %h cell0 %h", cell1[31:0], cell0[31:0]);
        end
    endtask

    task automatic test_reset_mid();
        bit tmo;
        int si;
        int i0;
        do_start();
        stream(ramp(32'h5000), 5, 1'b0, tmo, si);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (tmo || {word_ready, init, busy, done} !== 4'b0000 || logic_inputs !== '0) begin
            errors++;
            $display("FAIL mid_reset tmo %b outs %b lsw %h exp 0 0000 0", tmo, {word_ready, init, busy, done}, logic_inputs[31:0]);
        end
        i0 = init_cnt;
        tick();
        tick();
        rst_n = 1'b1;
        word_valid = 1'b1;
        repeat (20) tick();
        word_valid = 1'b0;
        checks++;
        if (busy !== 1'b0 || init_cnt !== i0 || word_ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_idle busy %b inits %0d ready %b exp 0 %0d 0", busy, init_cnt - i0, word_ready, 0);
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        start      = 1'b0;
        word_in    = '0;
        word_valid = 1'b0;
        test_reset();
        test_slicing();
        test_ordering();
        test_backpressure();
        test_protocol_misuse();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
